trap_ctrl: RTL and testbench

Commit-stage trap sequencer for the pipelined core. It detects `ecall`, `ebreak` and `mret` at write-back and waits for outstanding memory operations to drain. For exceptions it drives the one-cycle `trap` pulse into the CSR file, which records `mepc`/`mcause`. It then redirects fetch, either to the CSR-supplied `mtvec` (exceptions) or to `mepc` (`mret`), and flushes younger instructions.

---
 rtl/trap_ctrl_if.sv | 40 ++++
 rtl/trap_ctrl.sv | 95 +++++++++
 tb/tb_trap_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Write-back, CSR and fetch-redirect signals of the commit-stage trap sequencer.
// dbg_state mirrors the sequencer FSM for observation.
interface trap_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic             wb_valid_i;
  logic [XLEN-1:0]  wb_pc_i;
  logic [31:0]      wb_instr_i;
  logic             lsu_busy_i;
  logic [XLEN-1:0]  mtvec_i;
  logic [XLEN-1:0]  mepc_i;
  logic             trap_o;
  logic [XLEN-1:0]  trap_pc_o;
  logic [3:0]       cause_o;
  logic             stall_o;
  logic             flush_o;
  logic             redirect_valid_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             redirect_ready_i;
  logic [CNT_W-1:0] trap_cnt_o;
  logic [1:0]       dbg_state;

  // Redirect handshake: the request is held with a stable target while
  // redirect_valid_o=1 and redirect_ready_i=0; transfer happens on the cycle
  // both are high. Dropping redirect_valid_o without ready (reset) is a cancel.
  modport slave (
    input  wb_valid_i, wb_pc_i, wb_instr_i, lsu_busy_i, mtvec_i, mepc_i,
           redirect_ready_i,
    output trap_o, trap_pc_o, cause_o, stall_o, flush_o, redirect_valid_o,
           redirect_pc_o, trap_cnt_o, dbg_state
  );

  modport master (
    output wb_valid_i, wb_pc_i, wb_instr_i, lsu_busy_i, mtvec_i, mepc_i,
           redirect_ready_i,
    input  trap_o, trap_pc_o, cause_o, stall_o, flush_o, redirect_valid_o,
           redirect_pc_o, trap_cnt_o, dbg_state
  );
endinterface

// File: rtl/trap_ctrl.sv
// Commit-stage trap sequencer: catches ecall/ebreak/mret at write-back, drains
// the LSU, pulses trap into the CSR file and redirects fetch with a flush.
module trap_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input logic       clk,
  input logic       rst,
  trap_ctrl_if.slave bus
);
  localparam logic [31:0] ECALL_W  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;
  localparam logic [31:0] MRET_W   = 32'h3020_0073;

  typedef enum logic [1:0] {IDLE, DRAIN, TRAP, REDIRECT} state_t;
  typedef enum logic [1:0] {K_ECALL, K_EBREAK, K_MRET} kind_t;

  state_t           state, state_n;
  kind_t            kind, kind_n;
  logic [XLEN-1:0]  pc_q, pc_n;
  logic [XLEN-1:0]  target_q, target_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             is_ecall, is_ebreak, is_mret, hit;

  assign is_ecall  = (bus.wb_instr_i == ECALL_W);
  assign is_ebreak = (bus.wb_instr_i == EBREAK_W);
  assign is_mret   = (bus.wb_instr_i == MRET_W);
  assign hit       = bus.wb_valid_i && (state == IDLE) &&
                     (is_ecall || is_ebreak || is_mret);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      kind     <= K_ECALL;
      pc_q     <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state    <= state_n;
      kind     <= kind_n;
      pc_q     <= pc_n;
      target_q <= target_n;
      cnt_q    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    kind_n   = kind;
    pc_n     = pc_q;
    target_n = target_q;
    cnt_n    = cnt_q;
    case (state)
      IDLE: begin
        if (hit) begin
          pc_n    = bus.wb_pc_i;
          kind_n  = is_ecall ? K_ECALL : (is_ebreak ? K_EBREAK : K_MRET);
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.lsu_busy_i) begin
          if (kind == K_MRET) begin
            target_n = {bus.mepc_i[XLEN-1:2], 2'b00};
            state_n  = REDIRECT;
          end else begin
            state_n  = TRAP;
          end
        end
      end
      TRAP: begin
        // Target is captured here so later mtvec writes cannot move the redirect.
        target_n = {bus.mtvec_i[XLEN-1:2], 2'b00};
        if (cnt_q != {CNT_W{1'b1}}) cnt_n = cnt_q + CNT_W'(1);
        state_n  = REDIRECT;
      end
      REDIRECT: begin
        if (bus.redirect_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.trap_o           = (state == TRAP);
  assign bus.trap_pc_o        = (state == TRAP) ? pc_q : '0;
  assign bus.cause_o          = (state != TRAP)     ? 4'd0 :
                                (kind == K_EBREAK)  ? 4'd3 : 4'd11;
  // Combinational so the trapping instruction is held in its hit cycle.
  assign bus.stall_o          = hit || (state != IDLE);
  assign bus.flush_o          = (state == REDIRECT) && bus.redirect_ready_i;
  assign bus.redirect_valid_o = (state == REDIRECT);
  assign bus.redirect_pc_o    = target_q;
  assign bus.trap_cnt_o       = cnt_q;
  assign bus.dbg_state        = state;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: per-cycle vector table plus hand sequences for
// reset-in-redirect recovery and counter saturation (narrow-counter twin).
module tb_trap_ctrl;
  localparam int XLEN = 64;
  localparam logic [31:0] EC = 32'h0000_0073;
  localparam logic [31:0] EB = 32'h0010_0073;
  localparam logic [31:0] MR = 32'h3020_0073;
  localparam logic [63:0] MT = 64'h8000_0203;
  localparam logic [63:0] MP = 64'h8000_0104;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [63:0] pc;
    logic        busy;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic        rdy;
    logic        e_stall;
    logic        e_trap;
    logic [3:0]  e_cause;
    logic [63:0] e_tpc;
    logic        e_rv;
    logic [63:0] e_rpc;
    logic        e_flush;
    logic [15:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cur_row = 0;
  vec_t vecs[$];

  trap_ctrl_if #(.XLEN(XLEN), .CNT_W(16)) bus ();
  trap_ctrl_if #(.XLEN(XLEN), .CNT_W(3))  sbus ();

  trap_ctrl #(.XLEN(XLEN), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  trap_ctrl #(.XLEN(XLEN), .CNT_W(3))  dut_small (.clk(clk), .rst(rst), .bus(sbus));

  assign sbus.wb_valid_i       = bus.wb_valid_i;
  assign sbus.wb_pc_i          = bus.wb_pc_i;
  assign sbus.wb_instr_i       = bus.wb_instr_i;
  assign sbus.lsu_busy_i       = bus.lsu_busy_i;
  assign sbus.mtvec_i          = bus.mtvec_i;
  assign sbus.mepc_i           = bus.mepc_i;
  assign sbus.redirect_ready_i = bus.redirect_ready_i;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, cur_row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                              input logic busy, input logic [63:0] mtvec, input logic [63:0] mepc,
                              input logic rdy, input logic e_stall, input logic e_trap,
                              input logic [3:0] e_cause, input logic [63:0] e_tpc,
                              input logic e_rv, input logic [63:0] e_rpc, input logic e_flush,
                              input logic [15:0] e_cnt);
    vec_t r;
    r.v = v; r.ins = ins; r.pc = pc; r.busy = busy; r.mtvec = mtvec; r.mepc = mepc;
    r.rdy = rdy; r.e_stall = e_stall; r.e_trap = e_trap; r.e_cause = e_cause;
    r.e_tpc = e_tpc; r.e_rv = e_rv; r.e_rpc = e_rpc; r.e_flush = e_flush; r.e_cnt = e_cnt;
    return r;
  endfunction

  // Called just after a rising edge: drive, check mid-cycle, advance one cycle.
  task automatic apply(input vec_t r);
    logic [15:0] small_exp;
    bus.wb_valid_i       = r.v;
    bus.wb_instr_i       = r.ins;
    bus.wb_pc_i          = r.pc;
    bus.lsu_busy_i       = r.busy;
    bus.mtvec_i          = r.mtvec;
    bus.mepc_i           = r.mepc;
    bus.redirect_ready_i = r.rdy;
    @(negedge clk);
    small_exp = (r.e_cnt > 16'd7) ? 16'd7 : r.e_cnt;
    chk("stall", bus.stall_o, r.e_stall);
    chk("trap", bus.trap_o, r.e_trap);
    chk("cause", bus.cause_o, r.e_cause);
    chk("trap_pc", bus.trap_pc_o, r.e_tpc);
    chk("redirect_valid", bus.redirect_valid_o, r.e_rv);
    chk("redirect_pc", bus.redirect_pc_o, r.e_rpc);
    chk("flush", bus.flush_o, r.e_flush);
    chk("trap_cnt", bus.trap_cnt_o, r.e_cnt);
    chk("small_trap", sbus.trap_o, r.e_trap);
    chk("small_cnt", sbus.trap_cnt_o, small_exp);
    cur_row++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_ecall(input logic [63:0] pc, input logic [15:0] cb, input logic [63:0] rpcb);
    apply(mk(1, EC, pc, 0, MT, MP, 1, 1, 0, 0, 0, 0, rpcb, 0, cb));
    apply(mk(0, 0, 0, 0, MT, MP, 1, 1, 0, 0, 0, 0, rpcb, 0, cb));
    apply(mk(0, 0, 0, 0, MT, MP, 1, 1, 1, 4'd11, pc, 0, rpcb, 0, cb));
    apply(mk(0, 0, 0, 0, MT, MP, 1, 1, 0, 0, 0, 1, 64'h8000_0200, 1, cb + 16'd1));
  endtask

  initial begin
    // ecall, best case
    vecs.push_back(mk(1, EC, 64'h8000_0100, 0, MT, MP, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, MT, MP, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, MT, MP, 1, 1, 1, 4'd11, 64'h8000_0100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, MT, MP, 1, 1, 0, 0, 0, 1, 64'h8000_0200, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, MT, MP, 1, 0, 0, 0, 0, 0, 64'h8000_0200, 0, 1));
    // ebreak with three busy cycles; a valid ecall during DRAIN is ignored
    vecs.push_back(mk(1, EB, 64'h8000_0300, 0, 64'h8000_0404, MP, 1, 1, 0, 0, 0, 0, 64'h8000_0200, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 64'h8000_0404, MP, 1, 1, 0, 0, 0, 0, 64'h8000_0200, 0, 1));
    vecs.push_back(mk(1, EC, 64'h8000_0900, 1, 64'h8000_0404, MP, 1, 1, 0, 0, 0, 0, 64'h8000_0200, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 64'h8000_0404, MP, 1, 1, 0, 0, 0, 0, 64'h8000_0200, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 64'h8000_0404, MP, 1, 1, 0, 0, 0, 0, 64'h8000_0200, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 64'h8000_0404, MP, 1, 1, 1, 4'd3, 64'h8000_0300, 0, 64'h8000_0200, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 64'h8000_0404, MP, 1, 1, 0, 0, 0, 1, 64'h8000_0404, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 64'h8000_0404, MP, 1, 0, 0, 0, 0, 0, 64'h8000_0404, 0, 2));
    // mret; mepc changes after it was sampled
    vecs.push_back(mk(1, MR, 64'h8000_0500, 0, MT, MP, 1, 1, 0, 0, 0, 0, 64'h8000_0404, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, MT, MP, 1, 1, 0, 0, 0, 0, 64'h8000_0404, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, MT, 64'h8000_0ff0, 1, 1, 0, 0, 0, 1, 64'h8000_0104, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, MT, MP, 1, 0, 0, 0, 0, 0, 64'h8000_0104, 0, 2));
    // ecall with fetch back-pressure for 4 cycles while mtvec moves
    vecs.push_back(mk(1, EC, 64'h8000_0600, 0, 64'h8000_0800, MP, 0, 1, 0, 0, 0, 0, 64'h8000_0104, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 64'h8000_0800, MP, 0, 1, 0, 0, 0, 0, 64'h8000_0104, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 64'h8000_0800, MP, 0, 1, 1, 4'd11, 64'h8000_0600, 0, 64'h8000_0104, 0, 2));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 0, 64'h9000_0000, MP, 0, 1, 0, 0, 0, 1, 64'h8000_0800, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 64'h9000_0000, MP, 1, 1, 0, 0, 0, 1, 64'h8000_0800, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 64'h9000_0000, MP, 1, 0, 0, 0, 0, 0, 64'h8000_0800, 0, 3));
    // words that must be ignored
    vecs.push_back(mk(1, 32'h0000_0013, 64'h8000_0700, 0, MT, MP, 1, 0, 0, 0, 0, 0, 64'h8000_0800, 0, 3));
    vecs.push_back(mk(0, MR, 64'h8000_0704, 0, MT, MP, 1, 0, 0, 0, 0, 0, 64'h8000_0800, 0, 3));
    vecs.push_back(mk(1, 32'h0020_0073, 64'h8000_0708, 0, MT, MP, 1, 0, 0, 0, 0, 0, 64'h8000_0800, 0, 3));
    vecs.push_back(mk(1, 32'h3020_0072, 64'h8000_070c, 0, MT, MP, 1, 0, 0, 0, 0, 0, 64'h8000_0800, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, MT, MP, 1, 0, 0, 0, 0, 0, 64'h8000_0800, 0, 3));

    // clock/reset
    bus.wb_valid_i = 0; bus.wb_instr_i = 0; bus.wb_pc_i = 0; bus.lsu_busy_i = 0;
    bus.mtvec_i = 0; bus.mepc_i = 0; bus.redirect_ready_i = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_trap", bus.trap_o, 0);
    chk("rst_rv", bus.redirect_valid_o, 0);
    chk("rst_rpc", bus.redirect_pc_o, 0);
    chk("rst_cnt", bus.trap_cnt_o, 0);
    chk("rst_state", bus.dbg_state, 0);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // reset while a redirect is pending
    apply(mk(1, EC, 64'h8000_0a00, 0, MT, MP, 0, 1, 0, 0, 0, 0, 64'h8000_0800, 0, 3));
    apply(mk(0, 0, 0, 0, MT, MP, 0, 1, 0, 0, 0, 0, 64'h8000_0800, 0, 3));
    apply(mk(0, 0, 0, 0, MT, MP, 0, 1, 1, 4'd11, 64'h8000_0a00, 0, 64'h8000_0800, 0, 3));
    apply(mk(0, 0, 0, 0, MT, MP, 0, 1, 0, 0, 0, 1, 64'h8000_0200, 0, 4));
    rst = 1'b1;
    #1;
    chk("arst_rv", bus.redirect_valid_o, 0);
    chk("arst_rpc", bus.redirect_pc_o, 0);
    chk("arst_stall", bus.stall_o, 0);
    chk("arst_flush", bus.flush_o, 0);
    chk("arst_cnt", bus.trap_cnt_o, 0);
    chk("arst_state", bus.dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_ecall(64'h8000_0100, 16'd0, 64'd0);

    // narrow twin counter saturates at 7 and stays there
    for (int i = 1; i <= 8; i++)
      run_ecall(64'h8000_1000 + 64'(i * 4), 16'(i), 64'h8000_0200);
    chk("sat_small_final", sbus.trap_cnt_o, 3'd7);
    chk("main_cnt_final", bus.trap_cnt_o, 16'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
